i_mem_refill_arb: RTL and testbench

- Arbitrates i-cache line-refill traffic from two requesters onto the single instruction-memory port: demand misses from i_cache_top and next-line prefetches.
- Sequences one outstanding 128-bit line fetch at a time, routes the response to its owner and merges a demand miss into an in-flight prefetch of the same line.
- Sits between i_cache_top/prefetcher and i_mem.

---
 rtl/i_mem_refill_arb.sv | 189 ++++++++++++++++++
 tb/tb_i_mem_refill_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_refill_arb.sv
// Refill arbiter: grants demand misses and next-line prefetches onto the single
// i_mem port, one outstanding line at a time, with demand-into-prefetch merging.
module i_mem_refill_arb #(
   parameter int unsigned STARVE_LIMIT   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dmd_req_valid,
   input  logic [31:0]   dmd_req_addr,
   output logic          dmd_req_ready,
   input  logic          pf_req_valid,
   input  logic [31:0]   pf_req_addr,
   output logic          pf_req_ready,
   output logic          mem_req_valid,
   output logic [31:0]   mem_req_addr,
   input  logic          mem_req_ready,
   input  logic          mem_rsp_valid,
   input  logic [31:0]   mem_rsp_addr,
   input  logic [127:0]  mem_rsp_data,
   output logic          dmd_rsp_valid,
   output logic [31:0]   dmd_rsp_addr,
   output logic [127:0]  dmd_rsp_data,
   output logic          pf_rsp_valid,
   output logic [31:0]   pf_rsp_addr,
   output logic [127:0]  pf_rsp_data,
   output logic          busy,
   output logic          timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic {OWN_DMD, OWN_PF} owner_e;

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

   state_e         state_q, state_d;
   owner_e         owner_q, owner_d;
   logic           merge_q, merge_d;
   logic [31:0]    addr_q, addr_d;
   logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
   logic [TW-1:0]  timeout_cnt_q, timeout_cnt_d;
   logic           timeout_err_q, timeout_err_d;
   logic           dmd_rsp_valid_q, dmd_rsp_valid_d;
   logic [31:0]    dmd_rsp_addr_q, dmd_rsp_addr_d;
   logic [127:0]   dmd_rsp_data_q, dmd_rsp_data_d;
   logic           pf_rsp_valid_q, pf_rsp_valid_d;
   logic [31:0]    pf_rsp_addr_q, pf_rsp_addr_d;
   logic [127:0]   pf_rsp_data_q, pf_rsp_data_d;

   logic pf_grant;
   logic merge_now;
   logic rsp_hit;
   logic unused_low_bits;

   // Only line-address bits take part in matching; byte offsets are dropped.
   assign unused_low_bits = ^{dmd_req_addr[3:0], pf_req_addr[3:0], mem_rsp_addr[3:0]};

   assign rsp_hit   = mem_rsp_valid && (mem_rsp_addr[31:4] == addr_q[31:4]);
   assign pf_grant  = pf_req_valid && ((starve_cnt_q == STARVE_MAX) || !dmd_req_valid);
   assign merge_now = ((state_q == ISSUE) || (state_q == WAIT)) && (owner_q == OWN_PF) &&
                      !merge_q && dmd_req_valid && (dmd_req_addr[31:4] == addr_q[31:4]);

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      merge_d         = merge_q;
      addr_d          = addr_q;
      starve_cnt_d    = starve_cnt_q;
      timeout_cnt_d   = timeout_cnt_q;
      timeout_err_d   = timeout_err_q;
      dmd_rsp_valid_d = 1'b0;
      dmd_rsp_addr_d  = dmd_rsp_addr_q;
      dmd_rsp_data_d  = dmd_rsp_data_q;
      pf_rsp_valid_d  = 1'b0;
      pf_rsp_addr_d   = pf_rsp_addr_q;
      pf_rsp_data_d   = pf_rsp_data_q;
      dmd_req_ready   = 1'b0;
      pf_req_ready    = 1'b0;
      mem_req_valid   = 1'b0;

      if (merge_now) begin
         dmd_req_ready = 1'b1;
         merge_d       = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pf_grant) begin
               pf_req_ready = 1'b1;
               addr_d       = {pf_req_addr[31:4], 4'b0};
               owner_d      = OWN_PF;
               starve_cnt_d = '0;
               state_d      = ISSUE;
            end else begin
               if (pf_req_valid && (starve_cnt_q != STARVE_MAX))
                  starve_cnt_d = starve_cnt_q + SW'(1);
               if (dmd_req_valid) begin
                  dmd_req_ready = 1'b1;
                  addr_d        = {dmd_req_addr[31:4], 4'b0};
                  owner_d       = OWN_DMD;
                  state_d       = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               timeout_cnt_d = '0;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            // A match in the final timeout cycle takes priority over the reissue.
            if (rsp_hit) begin
               state_d = RESP;
               if (owner_q == OWN_PF) begin
                  pf_rsp_valid_d = 1'b1;
                  pf_rsp_addr_d  = addr_q;
                  pf_rsp_data_d  = mem_rsp_data;
               end
               if ((owner_q == OWN_DMD) || merge_q || merge_now) begin
                  dmd_rsp_valid_d = 1'b1;
                  dmd_rsp_addr_d  = addr_q;
                  dmd_rsp_data_d  = mem_rsp_data;
               end
            end else if (timeout_cnt_q == TIMEOUT_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = ISSUE;
            end else begin
               timeout_cnt_d = timeout_cnt_q + TW'(1);
            end
         end
         RESP: begin
            merge_d = 1'b0;
            owner_d = OWN_DMD;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the values settled by the combinational block in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= IDLE;
         owner_q         <= OWN_DMD;
         merge_q         <= 1'b0;
         addr_q          <= '0;
         starve_cnt_q    <= '0;
         timeout_cnt_q   <= '0;
         timeout_err_q   <= 1'b0;
         dmd_rsp_valid_q <= 1'b0;
         dmd_rsp_addr_q  <= '0;
         dmd_rsp_data_q  <= '0;
         pf_rsp_valid_q  <= 1'b0;
         pf_rsp_addr_q   <= '0;
         pf_rsp_data_q   <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         merge_q         <= merge_d;
         addr_q          <= addr_d;
         starve_cnt_q    <= starve_cnt_d;
         timeout_cnt_q   <= timeout_cnt_d;
         timeout_err_q   <= timeout_err_d;
         dmd_rsp_valid_q <= dmd_rsp_valid_d;
         dmd_rsp_addr_q  <= dmd_rsp_addr_d;
         dmd_rsp_data_q  <= dmd_rsp_data_d;
         pf_rsp_valid_q  <= pf_rsp_valid_d;
         pf_rsp_addr_q   <= pf_rsp_addr_d;
         pf_rsp_data_q   <= pf_rsp_data_d;
      end
   end

   assign mem_req_addr  = addr_q;
   assign dmd_rsp_valid = dmd_rsp_valid_q;
   assign dmd_rsp_addr  = dmd_rsp_addr_q;
   assign dmd_rsp_data  = dmd_rsp_data_q;
   assign pf_rsp_valid  = pf_rsp_valid_q;
   assign pf_rsp_addr   = pf_rsp_addr_q;
   assign pf_rsp_data   = pf_rsp_data_q;
   assign busy          = (state_q != IDLE);
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_i_mem_refill_arb.sv
// Directed bench for i_mem_refill_arb: steps a fixed scenario sequence and
// compares outputs against hand-computed values with immediate assertions.
module tb_i_mem_refill_arb;

   logic          clk;
   logic          rst;
   logic          dmd_req_valid;
   logic [31:0]   dmd_req_addr;
   logic          dmd_req_ready;
   logic          pf_req_valid;
   logic [31:0]   pf_req_addr;
   logic          pf_req_ready;
   logic          mem_req_valid;
   logic [31:0]   mem_req_addr;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [31:0]   mem_rsp_addr;
   logic [127:0]  mem_rsp_data;
   logic          dmd_rsp_valid;
   logic [31:0]   dmd_rsp_addr;
   logic [127:0]  dmd_rsp_data;
   logic          pf_rsp_valid;
   logic [31:0]   pf_rsp_addr;
   logic [127:0]  pf_rsp_data;
   logic          busy;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] D1 = 128'h01000000_02000000_03000000_04000000;
   localparam logic [127:0] D2 = 128'hdead0000_0000beef_12345678_9abcdef0;
   localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] D4 = 128'hcafef00d_00000001_00000002_00000003;
   localparam logic [127:0] D5 = 128'h55555555_aaaaaaaa_55555555_aaaaaaaa;
   localparam logic [127:0] D6 = 128'h66666666_00000000_66666666_00000006;
   localparam logic [127:0] D7 = 128'h77777777_77777777_00000000_00000007;
   localparam logic [127:0] D8 = 128'h88888888_88888888_88888888_88888888;
   localparam logic [127:0] D9 = 128'h99999999_00000000_00000000_99999999;
   localparam logic [127:0] DX = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;

   i_mem_refill_arb #(.STARVE_LIMIT(8), .TIMEOUT_CYCLES(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .dmd_req_valid (dmd_req_valid),
      .dmd_req_addr  (dmd_req_addr),
      .dmd_req_ready (dmd_req_ready),
      .pf_req_valid  (pf_req_valid),
      .pf_req_addr   (pf_req_addr),
      .pf_req_ready  (pf_req_ready),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_addr  (mem_rsp_addr),
      .mem_rsp_data  (mem_rsp_data),
      .dmd_rsp_valid (dmd_rsp_valid),
      .dmd_rsp_addr  (dmd_rsp_addr),
      .dmd_rsp_data  (dmd_rsp_data),
      .pf_rsp_valid  (pf_rsp_valid),
      .pf_rsp_addr   (pf_rsp_addr),
      .pf_rsp_data   (pf_rsp_data),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Land just after the rising edge; inputs set here are sampled at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   int  n_dmd;
   logic pf_won;
   logic pend_v;
   logic [31:0] pend_a;

   initial begin
      rst = 1'b0; dmd_req_valid = 1'b0; dmd_req_addr = '0; pf_req_valid = 1'b0;
      pf_req_addr = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      mem_rsp_addr = '0; mem_rsp_data = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_dmd_rsp_valid", dmd_rsp_valid, 0);
      check("rst_pf_rsp_valid", pf_rsp_valid, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_dmd_rsp_data", dmd_rsp_data, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      rst = 1'b1;
      tick();

      // Demand-only fetch
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_beef; settle();
      check("t1_dmd_ready", dmd_req_ready, 1);
      check("t1_pf_ready_low", pf_req_ready, 0);
      tick(); dmd_req_valid = 1'b0; settle();
      check("t1_mem_req_valid", mem_req_valid, 1);
      check("t1_mem_req_addr", mem_req_addr, 32'h0000_bee0);
      check("t1_busy", busy, 1);
      tick();
      check("t1_wait_no_req", mem_req_valid, 0);
      tick(); tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_bee0; mem_rsp_data = D1;
      tick(); mem_rsp_valid = 1'b0;
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_7770; settle();
      check("t1_dmd_rsp_valid", dmd_rsp_valid, 1);
      check("t1_dmd_rsp_data", dmd_rsp_data, D1);
      check("t1_dmd_rsp_addr", dmd_rsp_addr, 32'h0000_bee0);
      check("t1_pf_rsp_quiet", pf_rsp_valid, 0);
      check("t1_no_accept_in_resp", dmd_req_ready, 0);
      dmd_req_valid = 1'b0;
      tick();
      check("t1_rsp_one_cycle", dmd_rsp_valid, 0);
      check("t1_rsp_data_hold", dmd_rsp_data, D1);
      check("t1_idle_again", busy, 0);

      // Simultaneous requests plus a mismatched response while waiting
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_dea4;
      pf_req_valid = 1'b1; pf_req_addr = 32'h0000_1230; settle();
      check("t2_dmd_first", dmd_req_ready, 1);
      check("t2_pf_loses", pf_req_ready, 0);
      tick(); dmd_req_valid = 1'b0; settle();
      check("t2_issue_addr", mem_req_addr, 32'h0000_dea0);
      check("t2_pf_blocked_issue", pf_req_ready, 0);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_1110; mem_rsp_data = DX;
      tick(); mem_rsp_valid = 1'b0;
      check("t4_mismatch_ignored", dmd_rsp_valid, 0);
      check("t4_still_busy", busy, 1);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_dea0; mem_rsp_data = D2;
      tick(); mem_rsp_valid = 1'b0; settle();
      check("t4_rsp_valid", dmd_rsp_valid, 1);
      check("t4_rsp_data", dmd_rsp_data, D2);
      check("t4_rsp_addr", dmd_rsp_addr, 32'h0000_dea0);
      check("t4_pf_rsp_quiet", pf_rsp_valid, 0);
      check("t2_pf_blocked_resp", pf_req_ready, 0);
      tick();
      check("t2_pf_granted_after", pf_req_ready, 1);
      tick(); pf_req_valid = 1'b0; settle();
      check("t2_pf_issue_addr", mem_req_addr, 32'h0000_1230);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_1230; mem_rsp_data = D3;
      tick(); mem_rsp_valid = 1'b0;
      check("t2_pf_rsp_valid", pf_rsp_valid, 1);
      check("t2_pf_rsp_data", pf_rsp_data, D3);
      check("t2_pf_rsp_addr", pf_rsp_addr, 32'h0000_1230);
      check("t2_pf_rsp_no_dmd", dmd_rsp_valid, 0);
      check("t2_dmd_data_hold", dmd_rsp_data, D2);
      tick();

      // Starvation: demand held high, prefetch must win after 8 losses
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_2000;
      pf_req_valid = 1'b1; pf_req_addr = 32'h0000_3000; mem_rsp_data = DX;
      n_dmd = 0; pf_won = 1'b0; pend_v = 1'b0; pend_a = '0;
      for (int i = 0; i < 100 && !pf_won; i++) begin
         settle();
         if (pf_req_ready) begin
            pf_won = 1'b1;
         end else begin
            if (dmd_req_ready) n_dmd++;
            mem_rsp_valid = pend_v; mem_rsp_addr = pend_a;
            pend_v = mem_req_valid; pend_a = mem_req_addr;
            tick();
         end
      end
      check("t2_starve_pf_won", pf_won, 1);
      check("t2_starve_dmd_grants", n_dmd, 8);
      tick(); dmd_req_valid = 1'b0; pf_req_valid = 1'b0; mem_rsp_valid = 1'b0; settle();
      check("t2_starve_pf_addr", mem_req_addr, 32'h0000_3000);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_3000; mem_rsp_data = D5;
      tick(); mem_rsp_valid = 1'b0;
      check("t2_starve_pf_rsp", pf_rsp_valid, 1);
      tick();

      // Merge a demand into an in-flight prefetch of the same line
      pf_req_valid = 1'b1; pf_req_addr = 32'h0000_bee0; settle();
      check("t3_pf_ready", pf_req_ready, 1);
      tick(); pf_req_valid = 1'b0; mem_req_ready = 1'b0;
      tick();
      check("t3_issue_hold", mem_req_valid, 1);
      check("t3_issue_addr_stable", mem_req_addr, 32'h0000_bee0);
      mem_req_ready = 1'b1;
      tick();
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_bee8; settle();
      check("t3_merge_ready", dmd_req_ready, 1);
      tick();
      check("t3_merge_once", dmd_req_ready, 0);
      check("t3_single_req", mem_req_valid, 0);
      dmd_req_valid = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_bee0; mem_rsp_data = D4;
      tick(); mem_rsp_valid = 1'b0;
      check("t3_dmd_rsp_valid", dmd_rsp_valid, 1);
      check("t3_pf_rsp_valid", pf_rsp_valid, 1);
      check("t3_dmd_rsp_data", dmd_rsp_data, D4);
      check("t3_pf_rsp_data", pf_rsp_data, D4);
      check("t3_dmd_rsp_addr", dmd_rsp_addr, 32'h0000_bee0);
      tick();
      check("t3_idle", busy, 0);

      // Merge in the same cycle as the response; other-line demand refused
      pf_req_valid = 1'b1; pf_req_addr = 32'h0000_6660;
      tick(); pf_req_valid = 1'b0;
      tick();
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_7770; settle();
      check("t3_other_line_blocked", dmd_req_ready, 0);
      dmd_req_addr = 32'h0000_6664;
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_6660; mem_rsp_data = D6; settle();
      check("t3_merge_rsp_ready", dmd_req_ready, 1);
      tick(); dmd_req_valid = 1'b0; mem_rsp_valid = 1'b0;
      check("t3_late_merge_dmd", dmd_rsp_valid, 1);
      check("t3_late_merge_pf", pf_rsp_valid, 1);
      check("t3_late_merge_data", dmd_rsp_data, D6);
      tick();

      // Timeout and reissue
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_4448;
      tick(); dmd_req_valid = 1'b0;
      tick();
      repeat (63) tick();
      check("t5_no_early_timeout", timeout_err, 0);
      check("t5_no_early_reissue", mem_req_valid, 0);
      tick();
      check("t5_timeout_err", timeout_err, 1);
      check("t5_reissue_valid", mem_req_valid, 1);
      check("t5_reissue_addr", mem_req_addr, 32'h0000_4440);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_4440; mem_rsp_data = D7;
      tick(); mem_rsp_valid = 1'b0;
      check("t5_rsp_valid", dmd_rsp_valid, 1);
      check("t5_rsp_data", dmd_rsp_data, D7);
      tick();
      check("t5_err_sticky", timeout_err, 1);
      check("t5_idle", busy, 0);

      // Reset mid-transaction, then a late response
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_5554;
      tick(); dmd_req_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); rst = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_5550; mem_rsp_data = D8; settle();
      check("t6_busy", busy, 0);
      check("t6_mem_req_valid", mem_req_valid, 0);
      check("t6_timeout_err", timeout_err, 0);
      check("t6_dmd_rsp_addr", dmd_rsp_addr, 0);
      check("t6_dmd_rsp_data", dmd_rsp_data, 0);
      check("t6_pf_rsp_data", pf_rsp_data, 0);
      tick(); mem_rsp_valid = 1'b0;
      check("t6_late_rsp_dmd", dmd_rsp_valid, 0);
      check("t6_late_rsp_pf", pf_rsp_valid, 0);
      check("t6_still_idle", busy, 0);

      // A matching response in the final timeout cycle wins
      dmd_req_valid = 1'b1; dmd_req_addr = 32'h0000_8880;
      tick(); dmd_req_valid = 1'b0;
      tick();
      repeat (63) tick();
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h0000_8880; mem_rsp_data = D9;
      tick(); mem_rsp_valid = 1'b0;
      check("t5_edge_rsp_valid", dmd_rsp_valid, 1);
      check("t5_edge_rsp_data", dmd_rsp_data, D9);
      check("t5_edge_no_err", timeout_err, 0);
      check("t5_edge_no_reissue", mem_req_valid, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
